frame_aligner: RTL and testbench
================================

// Module: frame_aligner
// PURPOSE
//  Upstream producer for the dynamic 6-of-10 bit slice/mux stage. Accepts a 6-bit parallel
//  stream and keeps a 10-bit sliding window. Hunts for a 6-bit sync word at bit offsets 0..3
//  and locks once the sync word recurs at a fixed frame period.
//  Presents the window (win) and locked offset (sel) to the slice stage. The slice stage
//  outputs win[sel+5:sel].
// PARAMETERS
//  SYNC        6'b101100  sync word; must be nonzero
//  FRAME_LEN   8          beats per frame, sync beat included; range 2..256
//  LOCK_COUNT  3          consecutive sync hits needed to enter LOCKED; >=1
//  LOSS_COUNT  2          consecutive sync misses in LOCKED that drop lock; >=1
// PORTS
//  CLK        in   1   clock; all state updates on the rising edge
//  RESET      in   1   synchronous, active-high reset
//  in_data    in   6   input beat; bit 0 is the oldest bit
//  in_valid   in   1   in_data valid
//  in_ready   out  1   beat accepted when in_valid && in_ready
//  win        out  10  registered window; feeds the slice stage data input
//  sel        out  2   locked bit offset; feeds the slice stage select
//  out_valid  out  1   win/sel hold a fresh beat and state is LOCKED
//  out_ready  in   1   downstream accepts the beat when out_valid && out_ready
//  sof        out  1   out_valid beat is the sync (frame start) beat
//  locked     out  1   state == LOCKED
// BEHAVIOUR
//  Window: on accept, win <= {in_data, win[9:6]}. win[9:4] is the newest beat; win[3:0] is the
//    previous beat's bits [5:2]. The link guarantees word skew of 0..3 bits only.
//  fresh flag: set by accept, cleared by consume.
//  consume = fresh && (!out_valid || out_ready).
//  in_ready = !fresh || consume. This gives one-beat buffering and 1-cycle latency from
//    accept to out_valid.
//  primed: set on the 2nd accept after reset. No sync search while !primed.
//  match(k) = (win[k+5:k] == SYNC).
//  FSM and counters advance only on consume. States:
//   HUNT: if primed and any match(k), take the lowest k. Then sel<=k, frame_pos<=1, hit_cnt<=1,
//     and go to CONFIRM, or to LOCKED directly if LOCK_COUNT==1. Otherwise stay in HUNT.
//   CONFIRM: if frame_pos==0, check match(sel).
//     Hit: hit_cnt++; when hit_cnt reaches LOCK_COUNT, go to LOCKED with miss_cnt<=0.
//     Miss: go to HUNT, with no re-search on this beat.
//   LOCKED: if frame_pos==0, check match(sel).
//     Hit: miss_cnt<=0.
//     Miss: miss_cnt++; when it reaches LOSS_COUNT, go to HUNT.
//  frame_pos <= (frame_pos+1) mod FRAME_LEN on every consume in CONFIRM/LOCKED.
//  sel changes only on a HUNT->CONFIRM/LOCKED transition; it is held in all other states.
//  out_valid = fresh && state==LOCKED, using the current state before the update.
//  sof = out_valid && frame_pos==0. A missed sync beat in LOCKED still outputs with sof=1.
//  The beat that causes the LOCKED->HUNT transition is itself output. Later beats are dropped,
//    which means consumed with out_valid=0.
//  Backpressure: while out_valid && !out_ready, win, sel, sof, state and counters are held,
//    and in_ready=0.
//  Simultaneous accept and consume in one cycle is legal; fresh stays 1.
//  Reset values: win=0, sel=0, out_valid=0, sof=0, locked=0, in_ready=1, state=HUNT, and all
//    counters and flags 0.
//  RESET mid-operation discards any held beat and clears priming, so 2 new beats are needed
//    before hunting.
//  Widths: frame_pos is $clog2(FRAME_LEN) bits; hit/miss counters saturate and never wrap.
// TESTING
//  1 Reset: hold RESET 2 cycles -> win=0, sel=0, out_valid=0, locked=0, in_ready=1.
//  2 Lock: SYNC at offset 2 every 8 beats, out_ready=1 -> locked=1 after the 3rd sync beat,
//    sel=2; afterwards out_valid on every beat, sof exactly every 8th beat.
//  3 Loss: while LOCKED, corrupt one sync -> stays locked, sof still pulses; corrupt 2
//    consecutive syncs -> locked=0 after the 2nd, out_valid stops the next beat.
//  4 Backpressure: while LOCKED, out_ready=0 for 5 cycles with in_valid=1 -> win/sel/sof
//    stable, in_ready=0; after release every beat appears exactly once, in order.
//  5 Priority: SYNC matches at offsets 1 and 3 in one window -> sel=1.
//  6 Reset in LOCKED mid-frame -> next cycle locked=0, out_valid=0; a sync in the 1st new beat
//    is ignored, and hunting resumes from the 2nd beat.

Source files
------------

// File: rtl/frame_aligner.sv
// frame_aligner
//   Hunts for a 6-bit sync word inside a 10-bit sliding window built from a
//   6-bit parallel stream (bit 0 oldest). It locks once the sync word recurs
//   at the same bit offset every FRAME_LEN beats. While locked, it presents
//   the window and the locked offset to the downstream 6-of-10 slice stage.
//
// Ports
//   CLK        in   1   clock, rising edge
//   RESET      in   1   synchronous, active-high reset
//   in_data    in   6   input beat, bit 0 oldest
//   in_valid   in   1   in_data valid
//   in_ready   out  1   beat accepted when in_valid && in_ready
//   win        out  10  registered window, {newest beat, previous beat[5:2]}
//   sel        out  2   locked bit offset (slice = win[sel+5:sel])
//   out_valid  out  1   fresh beat held and state is LOCKED
//   out_ready  in   1   downstream accepts when out_valid && out_ready
//   sof        out  1   presented beat is the frame-start (sync) beat
//   locked     out  1   state is LOCKED
module frame_aligner #(
  parameter logic [5:0] SYNC       = 6'b101100,
  parameter int          FRAME_LEN  = 8,
  parameter int          LOCK_COUNT = 3,
  parameter int          LOSS_COUNT = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] win,
  output logic [1:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sof,
  output logic       locked
);

  localparam int FP_W   = $clog2(FRAME_LEN);
  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  localparam logic [FP_W-1:0]   FP_LAST  = FP_W'(FRAME_LEN - 1);
  localparam logic [HIT_W-1:0]  HIT_MAX  = HIT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LOSS_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              r_state;
  logic [9:0]          r_win;
  logic [1:0]          r_sel;
  logic                r_fresh;
  logic                r_seen1;
  logic                r_primed;
  logic [FP_W-1:0]     r_frame_pos;
  logic [HIT_W-1:0]    r_hit_cnt;
  logic [MISS_W-1:0]   r_miss_cnt;

  logic                w_out_valid;
  logic                w_consume;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_hunt_found;
  logic [1:0]          w_hunt_k;
  logic                w_sel_match;
  logic                w_fp_zero;
  logic [FP_W-1:0]     w_fp_next;
  logic [HIT_W-1:0]    w_hit_inc;
  logic [MISS_W-1:0]   w_miss_inc;

  function automatic logic match_at(input logic [9:0] w, input logic [1:0] k);
    return w[k +: 6] == SYNC;
  endfunction

  function automatic logic [HIT_W-1:0] hit_sat_inc(input logic [HIT_W-1:0] c);
    return (c == HIT_MAX) ? c : c + HIT_W'(1);
  endfunction

  function automatic logic [MISS_W-1:0] miss_sat_inc(input logic [MISS_W-1:0] c);
    return (c == MISS_MAX) ? c : c + MISS_W'(1);
  endfunction

  // Handshake and search (combinational on registered state)
  always_comb begin
    w_out_valid = r_fresh && (r_state == ST_LOCKED);
    // A held beat is consumed when nobody downstream needs to see it, or
    // when downstream takes it; dropped beats drain without out_ready.
    w_consume   = r_fresh && (!w_out_valid || out_ready);
    w_in_ready  = !r_fresh || w_consume;
    w_accept    = in_valid && w_in_ready;

    w_hunt_found = 1'b0;
    w_hunt_k     = 2'd0;
    // Descending scan so the lowest matching offset wins.
    for (int k = 3; k >= 0; k--) begin
      if (match_at(r_win, 2'(k))) begin
        w_hunt_found = 1'b1;
        w_hunt_k     = 2'(k);
      end
    end

    w_sel_match = match_at(r_win, r_sel);
    w_fp_zero   = (r_frame_pos == '0);
    w_fp_next   = (r_frame_pos == FP_LAST) ? '0 : r_frame_pos + FP_W'(1);
    w_hit_inc   = hit_sat_inc(r_hit_cnt);
    w_miss_inc  = miss_sat_inc(r_miss_cnt);
  end

  // Window capture and alignment FSM
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_HUNT;
      r_win       <= '0;
      r_sel       <= '0;
      r_fresh     <= 1'b0;
      r_seen1     <= 1'b0;
      r_primed    <= 1'b0;
      r_frame_pos <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_win   <= {in_data, r_win[9:6]};
        r_seen1 <= 1'b1;
        if (r_seen1) r_primed <= 1'b1;
      end

      if (w_accept)       r_fresh <= 1'b1;
      else if (w_consume) r_fresh <= 1'b0;

      if (w_consume) begin
        case (r_state)
          ST_HUNT: begin
            // The first beat after reset has a half-empty window; skip it.
            if (r_primed && w_hunt_found) begin
              r_sel       <= w_hunt_k;
              r_frame_pos <= FP_W'(1);
              r_hit_cnt   <= HIT_W'(1);
              if (LOCK_COUNT == 1) begin
                r_state    <= ST_LOCKED;
                r_miss_cnt <= '0;
              end else begin
                r_state <= ST_CONFIRM;
              end
            end
          end
          ST_CONFIRM: begin
            r_frame_pos <= w_fp_next;
            if (w_fp_zero) begin
              if (w_sel_match) begin
                r_hit_cnt <= w_hit_inc;
                if (w_hit_inc == HIT_MAX) begin
                  r_state    <= ST_LOCKED;
                  r_miss_cnt <= '0;
                end
              end else begin
                r_state <= ST_HUNT;
              end
            end
          end
          ST_LOCKED: begin
            r_frame_pos <= w_fp_next;
            if (w_fp_zero) begin
              if (w_sel_match) begin
                r_miss_cnt <= '0;
              end else begin
                r_miss_cnt <= w_miss_inc;
                if (w_miss_inc == MISS_MAX) r_state <= ST_HUNT;
              end
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  // Output stage
  assign in_ready  = w_in_ready;
  assign win       = r_win;
  assign sel       = r_sel;
  assign out_valid = w_out_valid;
  assign sof       = w_out_valid && w_fp_zero;
  assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_frame_aligner.sv
// tb_frame_aligner
//   Randomized stream bench for frame_aligner with a scoreboard. The stream
//   carries a sync word at offset 2 every 8 beats, with selected frames left
//   without sync to exercise lock hold and lock loss. Directed segments cover
//   reset, backpressure, offset priority and reset while locked.
module tb_frame_aligner;

  localparam logic [5:0] SYNC = 6'b101010;
  localparam int FL = 8;
  localparam int LC = 3;
  localparam int LS = 2;
  localparam int NB = 120;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] win;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic       sof;
  logic       locked;

  frame_aligner #(
    .SYNC(SYNC), .FRAME_LEN(FL), .LOCK_COUNT(LC), .LOSS_COUNT(LS)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .win(win), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .sof(sof), .locked(locked)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0] win;
    logic [1:0] sel;
    logic       sof;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   bp_en = 1'b0;

  logic [5:0] beats [NB];
  bit         sbits [NB*6];

  // Reference model: window = newest 10 stream bits; frame position is the
  // distance in beats from the beat where the sync was first found.
  int         m_mode;      // 0 hunting, 1 confirming, 2 locked
  int         m_sel;
  int         m_anchor;
  int         m_hits;
  int         m_misses;
  int         m_n;
  logic [5:0] m_prev;
  logic [9:0] m_win;
  exp_t       m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_anchor = 0; m_hits = 0; m_misses = 0;
    m_n = 0; m_prev = '0; m_win = '0;
  endtask

  task automatic model_beat(input logic [5:0] d);
    logic [9:0] w;
    int pos;
    int fk;
    exp_t e;
    w = {d, m_prev[5:2]};
    pos = (m_n - m_anchor) % FL;
    if (m_mode == 2) begin
      e.win = w; e.sel = 2'(m_sel); e.sof = (pos == 0);
      sb.push_back(e);
      m_last = e;
    end
    case (m_mode)
      0: begin
        if (m_n >= 1) begin
          fk = -1;
          for (int k = 3; k >= 0; k--) if (w[k +: 6] == SYNC) fk = k;
          if (fk >= 0) begin
            m_sel = fk; m_anchor = m_n; m_hits = 1; m_misses = 0;
            m_mode = (LC == 1) ? 2 : 1;
          end
        end
      end
      1: begin
        if (pos == 0) begin
          if (w[m_sel +: 6] == SYNC) begin
            m_hits++;
            if (m_hits >= LC) begin m_mode = 2; m_misses = 0; end
          end else begin
            m_mode = 0;
          end
        end
      end
      default: begin
        if (pos == 0) begin
          if (w[m_sel +: 6] == SYNC) m_misses = 0;
          else begin
            m_misses++;
            if (m_misses >= LS) m_mode = 0;
          end
        end
      end
    endcase
    m_win = w;
    m_prev = d;
    m_n++;
  endtask

  // Filler uses equal-bit pairs and the sync is fenced by copies of its end
  // bits, so the alternating sync word cannot appear anywhere but on purpose.
  task automatic build_stream();
    int base;
    int b;
    for (int p = 0; p < NB*3; p++) begin
      bit r;
      r = bit'($urandom_range(0, 1));
      sbits[2*p] = r;
      sbits[2*p+1] = r;
    end
    for (int f = 0; f < NB/FL; f++) begin
      if (f == 5 || f == 8 || f == 9) continue;
      b = FL*f + 3;
      base = 6*b - 2;
      sbits[base-1] = SYNC[0];
      for (int i = 0; i < 6; i++) sbits[base+i] = SYNC[i];
      sbits[base+6] = SYNC[5];
    end
    for (int bb = 0; bb < NB; bb++)
      for (int i = 0; i < 6; i++) beats[bb][i] = sbits[6*bb+i];
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Entered near a falling edge; returns on a falling edge after acceptance.
  task automatic send_beat(input logic [5:0] d);
    bit acc;
    int waitc;
    acc = 1'b0;
    waitc = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!acc) begin
      out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      acc = in_ready;
      @(posedge CLK);
      if (acc) model_beat(d);
      @(negedge CLK);
      waitc++;
      if (waitc > 200) begin
        checks++; failures++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", waitc);
        finish_now();
      end
    end
    in_valid = 1'b0;
    if (bp_en && $urandom_range(0, 3) == 0) begin
      out_ready = bit'($urandom_range(0, 1));
      @(negedge CLK);
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int b = lo; b <= hi; b++) send_beat(beats[b]);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_locked"}, locked, (m_mode == 2));
    check({tag, "_sel"}, sel, m_sel);
    check({tag, "_win"}, win, m_win);
  endtask

  // Monitor: pops one expectation per beat handed downstream.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (RESET !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: win=0x%0h sel=%0d sof=%0b, expected no beat", win, sel, sof);
        end else begin
          e = sb.pop_front();
          check("out_win", win, e.win);
          check("out_sel", sel, e.sel);
          check("out_sof", sof, e.sof);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    checks++; failures++;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    finish_now();
  end

  initial begin
    RESET = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_reset();
    build_stream();
    repeat (2) @(negedge CLK);
    #1;
    check("rst_win", win, 10'd0);
    check("rst_sel", sel, 2'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sof", sof, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    RESET = 1'b0;
    @(negedge CLK);

    bp_en = 1'b1;
    send_range(0, 26);
    drain();
    check_state("lock");
    check("lock_reached", locked, 1'b1);
    check("lock_sel", sel, 2'd2);

    send_range(27, 46);
    drain();
    check_state("one_miss");
    check("one_miss_still_locked", locked, 1'b1);

    send_range(47, 75);
    drain();
    check_state("two_miss");
    check("two_miss_lost", locked, 1'b0);

    send_range(76, 104);
    drain();
    check_state("relock");
    check("relock_reached", locked, 1'b1);

    // Backpressure while locked.
    in_data = beats[105]; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("bp_first_in_ready", in_ready, 1'b1);
    @(posedge CLK);
    model_beat(beats[105]);
    @(negedge CLK);
    in_data = beats[106]; in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_win", win, m_last.win);
      check("bp_sel", sel, m_last.sel);
      check("bp_sof", sof, m_last.sof);
      @(negedge CLK);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    @(posedge CLK);
    model_beat(beats[106]);
    @(negedge CLK);
    in_valid = 1'b0;
    send_range(107, 108);
    drain();
    check_state("after_bp");

    // Reset while a locked mid-frame beat is held.
    bp_en = 1'b0;
    in_data = beats[109]; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLK);
    model_beat(beats[109]);
    @(negedge CLK);
    in_valid = 1'b0;
    RESET = 1'b1;
    sb.delete();
    model_reset();
    @(negedge CLK);
    #1;
    check("midrst_locked", locked, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_win", win, 10'd0);
    RESET = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);

    // First beat carries a sync at offset 3 but is not searched; the second
    // beat's window matches at offsets 1 and 3.
    send_beat(6'b010101);
    drain();
    check_state("unprimed");
    check("unprimed_sel", sel, 2'd0);
    send_beat(6'b010101);
    drain();
    check_state("priority");
    check("priority_sel", sel, 2'd1);
    check("priority_not_locked", locked, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    finish_now();
  end

endmodule
